// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and sizes for the 8-source round-robin arbiter.
// Holds the FSM state encoding and the source/select widths.
package mux8_rr_arbiter_pkg;

   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the sources and the arbiter.
// The arbiter side is the slave modport; the requester side is the master modport.
interface mux8_rr_arbiter_if;
   import mux8_rr_arbiter_pkg::*;

   logic [NUM_SRC-1:0] Req;
   logic               Done;
   logic [NUM_SRC-1:0] Grant;
   logic [SEL_W-1:0]   Sel;
   logic               Valid;
   logic               Timeout;

   modport master (
      output Req,
      output Done,
      input  Grant,
      input  Sel,
      input  Valid,
      input  Timeout
   );

   modport slave (
      input  Req,
      input  Done,
      output Grant,
      output Sel,
      output Valid,
      output Timeout
   );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin search: first set Req bit starting at (Ptr+1) mod 8.
// Any is high when at least one source is requesting.
module rr_pick8
   import mux8_rr_arbiter_pkg::*;
(
   input  logic [NUM_SRC-1:0] Req,
   input  logic [SEL_W-1:0]   Ptr,
   output logic [SEL_W-1:0]   Win,
   output logic               Any
);

   logic [SEL_W-1:0] idx;

   // Walk from the farthest candidate back to the nearest so the nearest hit wins.
   always_comb begin
      Win = '0;
      idx = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = Ptr + SEL_W'(k);
         if (Req[idx]) begin
            Win = idx;
         end
      end
      Any = |Req;
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an external 8:1 data mux: registered one-hot Grant, Sel,
// Valid and a Timeout pulse when a grant is force-released after MAX_HOLD cycles.
module mux8_rr_arbiter
   import mux8_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input logic              Clk,
   input logic              Reset,
   mux8_rr_arbiter_if.slave bus
);

   arb_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic [SEL_W-1:0]   win;
   logic               any;
   logic               cnt_expired;
   logic               req_held;
   logic               release_now;

   rr_pick8 u_pick (
      .Req (bus.Req),
      .Ptr (ptr_q),
      .Win (win),
      .Any (any)
   );

   assign cnt_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
   assign req_held    = bus.Req[sel_q];
   assign release_now = bus.Done || !req_held || cnt_expired;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         ptr_q     <= SEL_W'(NUM_SRC - 1);
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any) state_d = GRANT;
         GRANT:   if (release_now) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d   = grant_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            valid_d = 1'b0;
            if (any) begin
               grant_d[win] = 1'b1;
               sel_d        = win;
               ptr_d        = win;
               cnt_d        = '0;
               valid_d      = 1'b1;
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_d   = '0;
               valid_d   = 1'b0;
               cnt_d     = '0;
               // Only a pure counter expiry reports a timeout.
               timeout_d = !bus.Done && req_held;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign bus.Grant   = grant_q;
   assign bus.Sel     = sel_q;
   assign bus.Valid   = valid_q;
   assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed cases plus random Req/Done
// compared every cycle against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

   localparam int unsigned MaxHold = 4;

   logic Clk;
   logic Reset;

   mux8_rr_arbiter_if bus ();

   mux8_rr_arbiter #(
      .MAX_HOLD (MaxHold)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 0;

   // Behavioural model state
   bit m_busy;
   bit m_timeout;
   int m_sel;
   int m_ptr;
   int m_held;
   int waits [8];

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
   endtask

   // Model: grant is visible for m_held cycles; release when held reaches MaxHold.
   always @(posedge Clk) begin
      if (Reset) begin
         m_busy    = 0;
         m_timeout = 0;
         m_sel     = 0;
         m_ptr     = 7;
         m_held    = 0;
         for (int i = 0; i < 8; i++) waits[i] = 0;
      end else begin
         for (int i = 0; i < 8; i++) if (!bus.Req[i]) waits[i] = 0;
         if (!m_busy) begin
            m_timeout = 0;
            if (bus.Req != 8'h00) begin
               int w;
               bit found;
               w = 0;
               found = 0;
               for (int k = 1; k <= 8; k++) begin
                  if (!found && bus.Req[(m_ptr + k) % 8]) begin
                     w = (m_ptr + k) % 8;
                     found = 1;
                  end
               end
               for (int i = 0; i < 8; i++) begin
                  if (i == w) waits[i] = 0;
                  else if (bus.Req[i]) waits[i]++;
               end
               m_busy = 1;
               m_sel  = w;
               m_ptr  = w;
               m_held = 1;
            end
         end else begin
            if (bus.Done || !bus.Req[m_sel] || m_held == int'(MaxHold)) begin
               m_timeout = !bus.Done && bus.Req[m_sel];
               m_busy    = 0;
            end else begin
               m_timeout = 0;
               m_held++;
            end
         end
      end
   end

   always @(negedge Clk) begin
      if (cmp_en) begin
         logic [7:0] exp_grant;
         int max_wait;
         exp_grant = m_busy ? (8'd1 << m_sel) : 8'd0;
         check("grant", bus.Grant, exp_grant);
         check("sel", bus.Sel, m_sel);
         check("valid", bus.Valid, m_busy);
         check("timeout", bus.Timeout, m_timeout);
         check("onehot0", $onehot0(bus.Grant), 1);
         if (bus.Valid) check("grant_vs_sel", bus.Grant, 8'd1 << bus.Sel);
         max_wait = 0;
         for (int i = 0; i < 8; i++) if (waits[i] > max_wait) max_wait = waits[i];
         check("fairness", max_wait > 7, 0);
      end
   end

   initial begin
      Reset    = 1'b1;
      bus.Req  = 8'h00;
      bus.Done = 1'b0;
      tick();
      tick();
      cmp_en = 1;
      check("rst_grant", bus.Grant, 8'h00);
      check("rst_sel", bus.Sel, 0);
      check("rst_valid", bus.Valid, 0);
      check("rst_timeout", bus.Timeout, 0);
      Reset = 1'b0;

      // Single request, released by Done
      bus.Req = 8'h01;
      tick();
      check("d27_grant", bus.Grant, 8'h01);
      check("d27_sel", bus.Sel, 0);
      check("d27_valid", bus.Valid, 1);
      bus.Done = 1'b1;
      tick();
      check("d27_rel_grant", bus.Grant, 8'h00);
      check("d27_rel_valid", bus.Valid, 0);
      bus.Done = 1'b0;
      bus.Req  = 8'h00;
      tick();

      // All requesting: rotation 0..7,0 with an idle cycle between grants
      Reset = 1'b1;
      tick();
      Reset   = 1'b0;
      bus.Req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check("d28_sel", bus.Sel, i % 8);
         check("d28_valid", bus.Valid, 1);
         tick();
         bus.Done = 1'b1;
         tick();
         check("d28_idle", bus.Valid, 0);
         bus.Done = 1'b0;
      end
      bus.Req = 8'h00;
      tick();

      // Wrap past the pointer
      Reset = 1'b1;
      tick();
      Reset   = 1'b0;
      bus.Req = 8'h20;
      tick();
      check("d29_first", bus.Sel, 5);
      bus.Done = 1'b1;
      tick();
      bus.Done = 1'b0;
      bus.Req  = 8'h21;
      tick();
      check("d29_wrap", bus.Sel, 0);
      bus.Done = 1'b1;
      tick();
      bus.Done = 1'b0;
      tick();
      check("d29_next", bus.Sel, 5);
      bus.Done = 1'b1;
      tick();
      bus.Done = 1'b0;
      bus.Req  = 8'h00;
      tick();

      // Counter expiry
      bus.Req = 8'h08;
      tick();
      check("d30_g1", bus.Grant, 8'h08);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("d30_hold", bus.Grant, 8'h08);
         check("d30_hold_to", bus.Timeout, 0);
      end
      tick();
      check("d30_drop", bus.Grant, 8'h00);
      check("d30_to", bus.Timeout, 1);
      tick();
      check("d30_to_pulse", bus.Timeout, 0);
      check("d30_regrant", bus.Grant, 8'h08);
      tick();
      tick();
      tick();
      bus.Done = 1'b1;
      tick();
      check("d30_done_drop", bus.Grant, 8'h00);
      check("d30_done_to", bus.Timeout, 0);
      bus.Done = 1'b0;
      bus.Req  = 8'h00;
      tick();

      // Request drop and reset mid-grant
      bus.Req = 8'h04;
      tick();
      check("d31_grant", bus.Grant, 8'h04);
      tick();
      bus.Req = 8'h00;
      tick();
      check("d31_drop", bus.Grant, 8'h00);
      check("d31_drop_to", bus.Timeout, 0);
      bus.Req = 8'h02;
      tick();
      check("d31_g2", bus.Grant, 8'h02);
      tick();
      Reset = 1'b1;
      tick();
      check("d31_rst_grant", bus.Grant, 8'h00);
      check("d31_rst_sel", bus.Sel, 0);
      check("d31_rst_valid", bus.Valid, 0);
      check("d31_rst_to", bus.Timeout, 0);
      Reset = 1'b0;

      // Random traffic
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 3) == 0) bus.Req = 8'($urandom);
         bus.Done = ($urandom_range(0, 7) == 0);
         Reset    = ($urandom_range(0, 999) == 0);
         tick();
      end
      Reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, max cycles one grant may be held (range 2..255).
REQ-002 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Req  input  8  request per source; bit i = source i of the 8:1 data mux.
REQ-005 SHALL have port Done  input  1  granted source finished; sampled only in GRANT.
REQ-006 SHALL have port Grant  output  8  one-hot grant, all-zero when idle.
REQ-007 SHALL have port Sel  output  3  binary index of the current or last grant; drives the 8:1 mux select.
REQ-008 SHALL have port Valid  output  1  high while a grant is active (Grant != 0).
REQ-009 SHALL have port Timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT; all outputs registered.
REQ-011 IDLE: if Req != 0, SHALL select the first set Req bit searching upward from (Ptr+1) mod 8, wrapping 7->0, and enter GRANT next cycle.
REQ-012 Entering GRANT SHALL set Grant one-hot at the winner, Sel = winner index, Valid=1, Ptr = winner, hold counter = 0; latency Req->Grant is exactly 1 cycle.
REQ-013 IDLE with Req == 0 SHALL remain in IDLE with Grant=0, Valid=0, and Sel holding its last value.
REQ-014 GRANT: counter SHALL increment by 1 each cycle; Grant and Sel SHALL remain stable.
REQ-015 GRANT SHALL release (next cycle IDLE, Grant=0, Valid=0) on any of: Done=1; Req[Sel]=0; counter == MAX_HOLD-1.
REQ-016 Release caused only by the counter (Done=0 and Req[Sel]=1) SHALL pulse Timeout=1 for the cycle Grant drops; Done or Req drop in the same cycle SHALL suppress Timeout.
REQ-017 After a release, at least one IDLE cycle SHALL occur before the next grant (no back-to-back grants).
REQ-018 Fairness: a continuously requesting source SHALL be granted within 8 grant rounds.
REQ-019 Req changes for non-granted sources during GRANT SHALL have no effect until the next IDLE.
REQ-020 Done asserted in IDLE SHALL be ignored.
REQ-021 Grant SHALL never have more than one bit set.

Reset
REQ-022 Reset=1 at a clock edge SHALL force IDLE, Grant=0, Sel=0, Valid=0, Timeout=0, counter=0, Ptr=7 (first search starts at source 0).
REQ-023 Reset mid-GRANT SHALL drop Grant the next cycle without a Timeout pulse; Reset SHALL take priority over all other inputs.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE=0, GRANT=1), NUM_SRC=8, and SEL_W=3.
REQ-025 The round-robin search SHALL be one combinational sub-module rr_pick8 (inputs Req, Ptr; outputs Win index, Any).
REQ-026 The block SHALL drive Sel only; the 8:1 data mux stays external and unchanged.

Verification
REQ-027 Reset, then Req=8'h01 -> next cycle Grant=8'h01, Sel=0, Valid=1; Done pulse -> next cycle Grant=0, Valid=0.
REQ-028 Req=8'hFF held, Done pulsed 2 cycles after each grant -> Sel sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-029 Ptr=5 (after granting 5), Req=8'h21 -> Sel=0 (wrap from 5 past 6,7); next round with Req=8'h21 -> Sel=5.
REQ-030 MAX_HOLD=4, Req=8'h08 held, Done=0 -> Grant=8'h08 for exactly 4 cycles, then Grant=0 with Timeout=1 for 1 cycle; counter-expiry cycle with Done=1 -> Timeout stays 0.
REQ-031 Granted Req bit dropped mid-grant -> Grant=0 next cycle, no Timeout; Reset asserted mid-grant -> all outputs 0 next cycle.
REQ-032 Random Req/Done for 10k cycles -> Grant always one-hot or zero, Grant == (1<<Sel) when Valid, no source starved beyond 8 rounds.
